trng_byte_collector: RTL and testbench
======================================

# trng_byte_collector

Consumer end of the debiased TRNG bit stream: accepts single bits qualified by a one-cycle valid strobe, packs them MSB-first into bytes, and buffers complete bytes in a small synchronous FIFO. Bytes leave on a ready/valid interface. It sits between the debiasing stage and any downstream reader, such as a serial transmitter or host register interface, in the same clock domain as the debiaser.

## Interface
- FIFO_DEPTH, 4, number of byte entries; power of two, minimum 2
- REP_LIMIT, 16, repetition-count cutoff for the health test; range 2..255
- i_clk  in  1  clock; same domain as the debiaser output
- i_rst_n  in  1  reset, asynchronous, active-low
- i_bit  in  1  random bit; sampled only when i_bit_valid=1
- i_bit_valid  in  1  one-cycle strobe qualifying i_bit
- i_clear  in  1  synchronous flush of the packer, FIFO, and sticky flags
- o_data  out  8  FIFO head byte; valid only while o_valid=1
- o_valid  out  1  FIFO non-empty
- i_ready  in  1  consumer accepts o_data when o_valid=1
- o_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- o_overflow  out  1  sticky; a completed byte was dropped
- o_health_fail  out  1  sticky; repetition-count test tripped

## Operation
- Packer: 7-bit shift register plus 3-bit bit counter. Each accepted bit updates the register as sr <= {sr[5:0], i_bit} and increments the counter.
- Byte completion: an accepted bit with counter==7 forms byte {sr[6:0], i_bit}, first-received bit as MSB. The counter wraps to 0 and a push request is issued.
- Push when full: if the FIFO is full and no pop occurs that cycle, the byte is dropped and o_overflow is set. A pop and a push in the same cycle while full are both performed; level stays at FIFO_DEPTH.
- Pop: occurs on o_valid && i_ready. Asserting i_ready while the FIFO is empty has no effect.
- Level: o_level counts pushes minus pops. It saturates by construction and never exceeds FIFO_DEPTH.
- FSM states, from trng_pkg:
  - COLLECT (reset state): normal packing.
  - FAIL: health test tripped. No bits are accepted, no pushes are made, and the partially packed byte is discarded. Pops continue, so buffered bytes drain.
  - FAIL is exited only by i_clear or reset.
- i_clear priority: i_clear beats all same-cycle events. It zeroes the counter, shift register, FIFO pointers, o_overflow and o_health_fail, and returns the FSM to COLLECT. The input bit and any push or pop in that cycle are ignored.
- Reset values: o_data=8'h00, o_valid=0, o_level=0, o_overflow=0, o_health_fail=0, FSM=COLLECT, counters=0.

## Timing
- A byte completed at edge N is visible at the head: o_valid=1 and o_data correct after edge N. Bit-to-output latency is 1 cycle.
- o_data is combinational from FIFO storage at the read pointer (show-ahead). It changes only on a pop, or on a push into an empty FIFO.
- Maximum throughput: one bit per cycle on input, one byte per cycle on output.
- Sticky flags assert on the edge that detects the event.
- Reset asserted mid-byte or mid-transfer clears the block immediately (asynchronous); no partial byte survives.

## Configuration
- TRNG_HEALTH_EN defined:
  - Repetition counter (8-bit) counts consecutive identical accepted bits.
  - When the count reaches REP_LIMIT, o_health_fail is set and the FSM enters FAIL on that edge. The bit causing the trip is not packed.
- TRNG_HEALTH_EN undefined:
  - No repetition counter.
  - o_health_fail is tied to 0 and the FSM never leaves COLLECT.

## Structure
- Shared package trng_pkg contains:
  - collector_state_t enum {COLLECT, FAIL}
  - TRNG_BYTE_W=8
  - default FIFO_DEPTH and REP_LIMIT constants
- Sub-module trng_sync_fifo (parameter DEPTH, WIDTH):
  - pointer-based, with an extra wrap bit for full/empty
  - show-ahead read
  - outputs full, empty and level

## Test plan
- Feed bits 1,0,1,1,0,0,1,0 with gaps between strobes -> o_data=8'hB2, o_valid=1 one edge after the 8th strobe, o_level=1.
- Feed 5 bytes with FIFO_DEPTH=4 and i_ready=0 -> first 4 bytes retained, 5th dropped, o_overflow=1, o_level=4. Then drain with i_ready=1 -> bytes emerge in order, o_valid=0 after the 4th pop.
- FIFO full, i_ready=1 on the same cycle a 5th byte completes -> no overflow, o_level stays 4, the new byte is last out.
- With TRNG_HEALTH_EN and REP_LIMIT=16, feed 16 consecutive 1s -> o_health_fail=1 on the 16th strobe. Further bits are ignored, and stored bytes (8'hFF) still drain.
- Pulse i_clear after 3 bits are packed and with overflow set -> counters, FIFO and flags cleared. The next 8 bits form a fresh byte.
- Assert i_rst_n=0 mid-byte with 2 bytes buffered -> all outputs are at reset values immediately.

Source files
------------

// File: rtl/trng_byte_collector_pkg.sv
// Shared types and defaults for the TRNG byte collector (package trng_pkg).
// Optional health test is enabled by defining TRNG_HEALTH_EN.
package trng_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        FAIL    = 1'b1
    } collector_state_t;

    localparam int TRNG_BYTE_W        = 8;
    localparam int DEFAULT_FIFO_DEPTH = 4;
    localparam int DEFAULT_REP_LIMIT  = 16;

    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/trng_byte_collector_if.sv
// Bit-in / byte-out bus of the TRNG byte collector.
// master = environment (bit source and byte consumer), slave = collector.
interface trng_byte_collector_if #(
    parameter int FIFO_DEPTH = trng_pkg::DEFAULT_FIFO_DEPTH
);
    import trng_pkg::*;

    logic                          rnd_bit;
    logic                          bit_valid;
    logic                          clear;
    logic [TRNG_BYTE_W-1:0]        data;
    logic                          valid;
    logic                          ready;
    logic [level_w(FIFO_DEPTH)-1:0] level;
    logic                          overflow;
    logic                          health_fail;

    modport master (
        output rnd_bit, bit_valid, clear, ready,
        input  data, valid, level, overflow, health_fail
    );

    modport slave (
        input  rnd_bit, bit_valid, clear, ready,
        output data, valid, level, overflow, health_fail
    );

endinterface

// File: rtl/trng_byte_collector_fifo.sv
// trng_sync_fifo: pointer FIFO with wrap bit and show-ahead head output.
// Head reads as zero while empty so the output is defined straight out of reset.
module trng_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign level   = wr_ptr_reg - rd_ptr_reg;
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty && !clear;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop) && !clear;
    assign rdata   = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/trng_byte_collector.sv
// Packs strobed TRNG bits MSB-first into bytes and buffers them for a ready/valid reader.
// Define TRNG_HEALTH_EN to add the repetition-count health test.
module trng_byte_collector
    import trng_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int REP_LIMIT  = DEFAULT_REP_LIMIT
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    trng_byte_collector_if.slave   bus
);
    collector_state_t       state_reg;
    logic [6:0]             sr_reg;
    logic [2:0]             cnt_reg;
    logic                   overflow_reg;
    logic                   health_fail_reg;

    logic                   accept;
    logic                   trip;
    logic                   pack;
    logic                   push_req;
    logic                   pop_req;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [TRNG_BYTE_W-1:0] new_byte;

    assign accept   = bus.bit_valid && (state_reg == COLLECT) && !bus.clear;
    assign pack     = accept && !trip;
    assign push_req = pack && (cnt_reg == 3'd7);
    assign new_byte = {sr_reg, bus.rnd_bit};
    assign pop_req  = bus.valid && bus.ready;

`ifdef TRNG_HEALTH_EN
    logic [7:0] rep_cnt_reg;
    logic [7:0] rep_cnt_next;
    logic       last_bit_reg;

    // Run length including the current bit; a fresh run starts at 1.
    assign rep_cnt_next = (rep_cnt_reg != 8'd0 && bus.rnd_bit == last_bit_reg)
                        ? rep_cnt_reg + 8'd1 : 8'd1;
    assign trip         = accept && (rep_cnt_next == 8'(REP_LIMIT));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rep_cnt_reg  <= '0;
            last_bit_reg <= 1'b0;
        end else if (bus.clear) begin
            rep_cnt_reg  <= '0;
            last_bit_reg <= 1'b0;
        end else if (accept) begin
            rep_cnt_reg  <= rep_cnt_next;
            last_bit_reg <= bus.rnd_bit;
        end
    end
`else
    logic unused_rep_limit;
    assign unused_rep_limit = ^8'(REP_LIMIT);
    assign trip             = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg       <= COLLECT;
            sr_reg          <= '0;
            cnt_reg         <= '0;
            overflow_reg    <= 1'b0;
            health_fail_reg <= 1'b0;
        end else if (bus.clear) begin
            state_reg       <= COLLECT;
            sr_reg          <= '0;
            cnt_reg         <= '0;
            overflow_reg    <= 1'b0;
            health_fail_reg <= 1'b0;
        end else begin
            case (state_reg)
                COLLECT: begin
                    if (trip) begin
                        // The tripping bit is not packed and the partial byte is discarded.
                        state_reg       <= FAIL;
                        health_fail_reg <= 1'b1;
                        sr_reg          <= '0;
                        cnt_reg         <= '0;
                    end else if (pack) begin
                        sr_reg  <= {sr_reg[5:0], bus.rnd_bit};
                        cnt_reg <= cnt_reg + 3'd1;
                    end
                    if (push_req && fifo_full && !pop_req) overflow_reg <= 1'b1;
                end
                FAIL: begin
                    state_reg <= FAIL;
                end
                default: state_reg <= COLLECT;
            endcase
        end
    end

    trng_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (TRNG_BYTE_W)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clear (bus.clear),
        .push  (push_req),
        .pop   (pop_req),
        .wdata (new_byte),
        .rdata (bus.data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (bus.level)
    );

    assign bus.valid       = !fifo_empty;
    assign bus.overflow    = overflow_reg;
    assign bus.health_fail = health_fail_reg;

endmodule

// File: tb/tb_trng_byte_collector.sv
// Directed bench for trng_byte_collector: queue-based model checked every cycle plus literal checks.
module tb_trng_byte_collector;
    import trng_pkg::*;

    localparam int DEPTH = DEFAULT_FIFO_DEPTH;
    localparam int REP   = DEFAULT_REP_LIMIT;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    bit   chk_en = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    trng_byte_collector_if #(.FIFO_DEPTH(DEPTH)) bus ();

    trng_byte_collector #(
        .FIFO_DEPTH (DEPTH),
        .REP_LIMIT  (REP)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    // Behavioural model: byte queue, partial byte, sticky flags, run length.
    logic [7:0] m_q[$];
    logic [7:0] m_acc;
    int         m_nbits;
    bit         m_ovf;
    bit         m_hf;
    bit         m_failed;
    int         m_run;
    logic       m_last;

    task automatic m_reset();
        m_q.delete();
        m_acc    = 8'h00;
        m_nbits  = 0;
        m_ovf    = 1'b0;
        m_hf     = 1'b0;
        m_failed = 1'b0;
        m_run    = 0;
        m_last   = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic b, input logic bv, input logic clr, input logic rdy);
        logic [7:0] nb;
        bit         have;
        bit         popped;
        bit         trip;
        have = 1'b0;
        trip = 1'b0;
        nb   = 8'h00;
        if (clr) begin
            $display("[TB] clear");
            m_reset();
            return;
        end
        popped = (m_q.size() != 0) && rdy;
        if (bv && !m_failed) begin
`ifdef TRNG_HEALTH_EN
            m_run  = (m_run > 0 && b == m_last) ? m_run + 1 : 1;
            m_last = b;
            if (m_run == REP) trip = 1'b1;
`endif
            if (trip) begin
                m_failed = 1'b1;
                m_hf     = 1'b1;
                m_nbits  = 0;
                m_acc    = 8'h00;
                $display("[TB] health test tripped");
            end else begin
                m_acc = {m_acc[6:0], b};
                m_nbits++;
                if (m_nbits == 8) begin
                    nb      = m_acc;
                    have    = 1'b1;
                    m_nbits = 0;
                end
            end
        end
        if (popped) begin
            $display("[TB] pop  byte=0x%02h", m_q[0]);
            void'(m_q.pop_front());
        end
        if (have) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back(nb);
                $display("[TB] push byte=0x%02h level=%0d", nb, m_q.size());
            end else begin
                m_ovf = 1'b1;
                $display("[TB] drop byte=0x%02h (buffer full)", nb);
            end
        end
    endtask

    // Cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("valid",       32'(bus.valid),       32'(m_q.size() != 0));
            check("level",       32'(bus.level),       32'(m_q.size()));
            check("overflow",    32'(bus.overflow),    32'(m_ovf));
            check("health_fail", 32'(bus.health_fail), 32'(m_hf));
            if (m_q.size() != 0) check("data", 32'(bus.data), 32'(m_q[0]));
        end
    end

    task automatic step(input logic b, input logic bv, input logic clr, input logic rdy);
        bus.rnd_bit   = b;
        bus.bit_valid = bv;
        bus.clear     = clr;
        bus.ready     = rdy;
        @(posedge clk);
        if (rst_n) model_update(b, bv, clr, rdy);
        #1;
        bus.rnd_bit   = 1'b0;
        bus.bit_valid = 1'b0;
        bus.clear     = 1'b0;
        bus.ready     = 1'b0;
    endtask

    task automatic feed_byte(input logic [7:0] v, input logic rdy_last);
        for (int i = 7; i >= 0; i--) step(v[i], 1'b1, 1'b0, (i == 0) ? rdy_last : 1'b0);
    endtask

    task automatic drain_expect(input string name, input logic [7:0] exp);
        check(name, 32'(bus.data), 32'(exp));
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [7:0] pat;
        m_reset();
        bus.rnd_bit   = 1'b0;
        bus.bit_valid = 1'b0;
        bus.clear     = 1'b0;
        bus.ready     = 1'b0;

        // Reset state
        #12;
        check("rst_valid",  32'(bus.valid),       32'd0);
        check("rst_level",  32'(bus.level),       32'd0);
        check("rst_data",   32'(bus.data),        32'h00);
        check("rst_ovf",    32'(bus.overflow),    32'd0);
        check("rst_hf",     32'(bus.health_fail), 32'd0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Gapped strobes 1,0,1,1,0,0,1,0 -> 0xB2 visible one edge after the 8th
        pat = 8'hB2;
        for (int i = 7; i >= 0; i--) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            step(pat[i], 1'b1, 1'b0, 1'b0);
        end
        check("b2_valid", 32'(bus.valid), 32'd1);
        check("b2_data",  32'(bus.data),  32'hB2);
        check("b2_level", 32'(bus.level), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("b2_popped", 32'(bus.level), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("empty_ready_noop", 32'(bus.level), 32'd0);

        // Five bytes into a 4-deep FIFO with the reader stalled
        feed_byte(8'h11, 1'b0);
        feed_byte(8'h22, 1'b0);
        feed_byte(8'h33, 1'b0);
        feed_byte(8'h44, 1'b0);
        feed_byte(8'h55, 1'b0);
        check("ovf_set",   32'(bus.overflow), 32'd1);
        check("ovf_level", 32'(bus.level),    32'd4);
        drain_expect("drain0", 8'h11);
        drain_expect("drain1", 8'h22);
        drain_expect("drain2", 8'h33);
        drain_expect("drain3", 8'h44);
        check("drain_empty", 32'(bus.valid),    32'd0);
        check("ovf_sticky",  32'(bus.overflow), 32'd1);

        // Clear mid-byte with overflow set; bit in the clear cycle is ignored
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("clr_ovf",   32'(bus.overflow), 32'd0);
        check("clr_level", 32'(bus.level),    32'd0);
        check("clr_data",  32'(bus.data),     32'h00);
        feed_byte(8'h5A, 1'b0);
        check("clr_fresh", 32'(bus.data),  32'h5A);
        check("clr_lvl1",  32'(bus.level), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Full FIFO with a pop in the cycle the 5th byte completes
        feed_byte(8'hA1, 1'b0);
        feed_byte(8'hB2, 1'b0);
        feed_byte(8'hC3, 1'b0);
        feed_byte(8'hD4, 1'b0);
        feed_byte(8'hE5, 1'b1);
        check("fullpop_ovf",   32'(bus.overflow), 32'd0);
        check("fullpop_level", 32'(bus.level),    32'd4);
        drain_expect("fp0", 8'hB2);
        drain_expect("fp1", 8'hC3);
        drain_expect("fp2", 8'hD4);
        drain_expect("fp3", 8'hE5);
        check("fp_empty", 32'(bus.valid), 32'd0);

        // Sixteen consecutive ones
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            if (i == 14) check("hf_before", 32'(bus.health_fail), 32'd0);
        end
`ifdef TRNG_HEALTH_EN
        check("hf_trip",   32'(bus.health_fail), 32'd1);
        check("hf_level",  32'(bus.level),       32'd1);
        check("hf_data",   32'(bus.data),        32'hFF);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("hf_ignored", 32'(bus.level), 32'd1);
        drain_expect("hf_drain", 8'hFF);
        check("hf_empty", 32'(bus.valid),       32'd0);
        check("hf_stick", 32'(bus.health_fail), 32'd1);
`else
        check("hf_off",    32'(bus.health_fail), 32'd0);
        check("hf_level",  32'(bus.level),       32'd2);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("hf_level3", 32'(bus.level), 32'd3);
        drain_expect("hf_drain0", 8'hFF);
        drain_expect("hf_drain1", 8'hFF);
        drain_expect("hf_drain2", 8'h00);
        check("hf_empty", 32'(bus.valid), 32'd0);
`endif
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("clr_hf", 32'(bus.health_fail), 32'd0);

        // Asynchronous reset mid-byte with two bytes buffered
        feed_byte(8'h3C, 1'b0);
        feed_byte(8'hC3, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("pre_rst_level", 32'(bus.level), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus.valid),       32'd0);
        check("arst_level", 32'(bus.level),       32'd0);
        check("arst_data",  32'(bus.data),        32'h00);
        check("arst_ovf",   32'(bus.overflow),    32'd0);
        check("arst_hf",    32'(bus.health_fail), 32'd0);
        m_reset();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        feed_byte(8'h96, 1'b0);
        check("post_rst_data",  32'(bus.data),  32'h96);
        check("post_rst_level", 32'(bus.level), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
